// File: rtl/kb_ascii_decoder.sv
// PS/2 Set 2 scan-code to ASCII decoder with shift/caps tracking and an output FIFO.
// A printable make code is written into the FIFO one cycle after its strobe.
module kb_ascii_decoder #(
  parameter int FIFO_DEPTH    = 8,
  parameter bit LOWER_CASE_EN = 1'b1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [7:0]                    scan_code,
  input  logic                          scan_valid,
  output logic [7:0]                    ascii_data,
  output logic                          ascii_valid,
  input  logic                          ascii_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          shift_active,
  output logic                          caps_lock,
  output logic                          overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  localparam logic [7:0] CODE_BREAK  = 8'hF0;
  localparam logic [7:0] CODE_EXT    = 8'hE0;
  localparam logic [7:0] CODE_LSHIFT = 8'h12;
  localparam logic [7:0] CODE_RSHIFT = 8'h59;
  localparam logic [7:0] CODE_CAPS   = 8'h58;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_BREAK     = 2'd1,
    ST_EXT       = 2'd2,
    ST_EXT_BREAK = 2'd3
  } state_t;

  // Returns {hit, ascii}; hit=0 for codes with no printable meaning.
  function automatic logic [8:0] map_make(
    input logic [7:0] code,
    input logic       upper,
    input logic       shifted
  );
    logic       is_letter;
    logic [7:0] up;
    logic [8:0] r;
    is_letter = 1'b1;
    up        = 8'h00;
    r         = 9'h000;
    case (code)
      8'h1C: up = 8'h41;  8'h32: up = 8'h42;  8'h21: up = 8'h43;
      8'h23: up = 8'h44;  8'h24: up = 8'h45;  8'h2B: up = 8'h46;
      8'h34: up = 8'h47;  8'h33: up = 8'h48;  8'h43: up = 8'h49;
      8'h3B: up = 8'h4A;  8'h42: up = 8'h4B;  8'h4B: up = 8'h4C;
      8'h3A: up = 8'h4D;  8'h31: up = 8'h4E;  8'h44: up = 8'h4F;
      8'h4D: up = 8'h50;  8'h15: up = 8'h51;  8'h2D: up = 8'h52;
      8'h1B: up = 8'h53;  8'h2C: up = 8'h54;  8'h3C: up = 8'h55;
      8'h2A: up = 8'h56;  8'h1D: up = 8'h57;  8'h22: up = 8'h58;
      8'h35: up = 8'h59;  8'h1A: up = 8'h5A;
      default: is_letter = 1'b0;
    endcase
    if (is_letter) begin
      r = {1'b1, (upper ? up : (up | 8'h20))};
    end else begin
      case (code)
        8'h45: r = {1'b1, (shifted ? 8'h29 : 8'h30)};
        8'h16: r = {1'b1, (shifted ? 8'h21 : 8'h31)};
        8'h1E: r = {1'b1, (shifted ? 8'h40 : 8'h32)};
        8'h26: r = {1'b1, (shifted ? 8'h23 : 8'h33)};
        8'h25: r = {1'b1, (shifted ? 8'h24 : 8'h34)};
        8'h2E: r = {1'b1, (shifted ? 8'h25 : 8'h35)};
        8'h36: r = {1'b1, (shifted ? 8'h5E : 8'h36)};
        8'h3D: r = {1'b1, (shifted ? 8'h26 : 8'h37)};
        8'h3E: r = {1'b1, (shifted ? 8'h2A : 8'h38)};
        8'h46: r = {1'b1, (shifted ? 8'h28 : 8'h39)};
        8'h29: r = {1'b1, 8'h20};
        8'h5A: r = {1'b1, 8'h0D};
        8'h66: r = {1'b1, 8'h08};
        default: r = 9'h000;
      endcase
    end
    return r;
  endfunction

  state_t          state_q, state_d;
  logic            lshift_q, lshift_d;
  logic            rshift_q, rshift_d;
  logic            caps_held_q, caps_held_d;
  logic            caps_lock_q, caps_lock_d;
  logic            overflow_q, overflow_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [7:0]      mem_q [FIFO_DEPTH];

  logic            push_s;
  logic [7:0]      push_data_s;
  logic            upper_s;
  logic [8:0]      map_s;
  logic            pop_s;
  logic            full_s;
  logic            wr_en_s;

  assign upper_s = ((lshift_q | rshift_q) ^ caps_lock_q) | ~LOWER_CASE_EN;
  assign map_s   = map_make(scan_code, upper_s, lshift_q | rshift_q);

  // Byte sequencer: prefix tracking, modifier state and push request.
  always_comb begin
    state_d     = state_q;
    lshift_d    = lshift_q;
    rshift_d    = rshift_q;
    caps_held_d = caps_held_q;
    caps_lock_d = caps_lock_q;
    push_s      = 1'b0;
    push_data_s = 8'h00;
    if (scan_valid) begin
      case (state_q)
        ST_IDLE: begin
          if (scan_code == CODE_BREAK) begin
            state_d = ST_BREAK;
          end else if (scan_code == CODE_EXT) begin
            state_d = ST_EXT;
          end else if (scan_code == CODE_LSHIFT) begin
            lshift_d = 1'b1;
          end else if (scan_code == CODE_RSHIFT) begin
            rshift_d = 1'b1;
          end else if (scan_code == CODE_CAPS) begin
            // Typematic repeats of caps arrive while caps_held is set and must not toggle.
            if (!caps_held_q) begin
              caps_lock_d = ~caps_lock_q;
            end else begin
              caps_lock_d = caps_lock_q;
            end
            caps_held_d = 1'b1;
          end else begin
            push_s      = map_s[8];
            push_data_s = map_s[7:0];
          end
        end
        ST_BREAK: begin
          state_d = ST_IDLE;
          if (scan_code == CODE_LSHIFT) begin
            lshift_d = 1'b0;
          end else if (scan_code == CODE_RSHIFT) begin
            rshift_d = 1'b0;
          end else if (scan_code == CODE_CAPS) begin
            caps_held_d = 1'b0;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_EXT: begin
          if (scan_code == CODE_BREAK) begin
            state_d = ST_EXT_BREAK;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_EXT_BREAK: state_d = ST_IDLE;
        default:      state_d = ST_IDLE;
      endcase
    end else begin
      state_d = state_q;
    end
  end

  assign pop_s   = (count_q != {CW{1'b0}}) && ascii_ready;
  assign full_s  = (count_q == DEPTH_C);
  assign wr_en_s = push_s && (!full_s || pop_s);

  // FIFO pointer, occupancy and sticky overflow next-state.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (wr_en_s) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({wr_en_s, pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (push_s && full_s && !pop_s) begin
      overflow_d = 1'b1;
    end else begin
      overflow_d = overflow_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      lshift_q    <= 1'b0;
      rshift_q    <= 1'b0;
      caps_held_q <= 1'b0;
      caps_lock_q <= 1'b0;
      overflow_q  <= 1'b0;
      wr_ptr_q    <= {AW{1'b0}};
      rd_ptr_q    <= {AW{1'b0}};
      count_q     <= {CW{1'b0}};
    end else begin
      state_q     <= state_d;
      lshift_q    <= lshift_d;
      rshift_q    <= rshift_d;
      caps_held_q <= caps_held_d;
      caps_lock_q <= caps_lock_d;
      overflow_q  <= overflow_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
    end
  end

  // FIFO storage; contents are only observable through valid entries.
  always_ff @(posedge clk) begin
    if (wr_en_s && !reset) begin
      mem_q[wr_ptr_q] <= push_data_s;
    end
  end

  assign ascii_valid  = (count_q != {CW{1'b0}});
  assign ascii_data   = ascii_valid ? mem_q[rd_ptr_q] : 8'h00;
  assign fifo_count   = count_q;
  assign shift_active = lshift_q | rshift_q;
  assign caps_lock    = caps_lock_q;
  assign overflow     = overflow_q;

endmodule
